// File: rtl/sprite_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite RAM between NUM_REQ
// requesters, with bounded burst locking and a tagged read-return path.
module sprite_ram_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned MAX_BURST   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_en,
  input  logic [DATA_W-1:0]         ram_q,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;

  typedef enum logic {S_RR, S_LOCKED} state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_burst, w_burst_nxt, w_cur_cnt;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any, w_lock_hit;
  logic [NUM_REQ-1:0] w_mask, w_req_hi, w_gnt;
  logic [NUM_REQ-1:0] r_pipe [RAM_LATENCY];

  function automatic logic [PTR_W-1:0] f_lowest(input logic [NUM_REQ-1:0] v);
    logic found;
    f_lowest = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (v[i] && !found) begin
        f_lowest = PTR_W'(i);
        found    = 1'b1;
      end
    end
  endfunction

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) w_mask[i] = (PTR_W'(i) >= r_ptr);
  end

  // Rotating priority as two flat searches: requesters at/above r_ptr first,
  // then wrap to the lowest asserted index.
  always_comb begin
    w_lock_hit  = (r_state == S_LOCKED) && req[r_owner];
    w_req_hi    = req & w_mask;
    w_any       = 1'b0;
    w_idx       = '0;
    w_state_nxt = S_RR;
    w_owner_nxt = '0;
    w_burst_nxt = '0;
    w_ptr_nxt   = r_ptr;
    w_cur_cnt   = w_lock_hit ? r_burst : '0;

    if (!reset) begin
      if (w_lock_hit) begin
        w_any = 1'b1;
        w_idx = r_owner;
      end else if (|w_req_hi) begin
        w_any = 1'b1;
        w_idx = f_lowest(w_req_hi);
      end else if (|req) begin
        w_any = 1'b1;
        w_idx = f_lowest(req);
      end
    end

    w_gnt        = '0;
    w_gnt[w_idx] = w_any;

    if (w_any) begin
      w_ptr_nxt = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (req_lock[w_idx] && (w_cur_cnt < CNT_W'(MAX_BURST - 1))) begin
        w_state_nxt = S_LOCKED;
        w_owner_nxt = w_idx;
        w_burst_nxt = w_cur_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RR;
      r_ptr   <= '0;
      r_owner <= '0;
      r_burst <= '0;
      r_pipe  <= '{default: '0};
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_burst   <= w_burst_nxt;
      r_pipe[0] <= w_gnt;
      for (int unsigned i = 1; i < RAM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign gnt      = w_gnt;
  assign ram_en   = w_any;
  assign ram_addr = w_any ? req_addr[32'(w_idx)*ADDR_W +: ADDR_W] : '0;
  assign rd_valid = reset ? '0 : r_pipe[RAM_LATENCY-1];
  assign rd_data  = ram_q;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Self-checking bench: two arbiter instances (RAM latency 1 and 3) share stimulus
// and are compared every cycle against a spec-level model, plus literal checks.
module tb_sprite_ram_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;
  localparam int HN = 16384;

  logic        clk, reset;
  logic [3:0]  req, req_lock;
  logic [63:0] req_addr;

  logic [3:0]  gnt1, gnt3, rd_valid1, rd_valid3;
  logic [15:0] ram_addr1, ram_addr3;
  logic        ram_en1, ram_en3;
  logic [11:0] ram_q1, ram_q3, rd_data1, rd_data3;

  logic [15:0] ram1_d, ram3_a, ram3_b, ram3_c;

  int total = 0;
  int bad   = 0;

  sprite_ram_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(12), .RAM_LATENCY(1), .MAX_BURST(8)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .gnt(gnt1), .ram_addr(ram_addr1), .ram_en(ram_en1), .ram_q(ram_q1),
    .rd_valid(rd_valid1), .rd_data(rd_data1));

  sprite_ram_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(12), .RAM_LATENCY(3), .MAX_BURST(8)) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .gnt(gnt3), .ram_addr(ram_addr3), .ram_en(ram_en3), .ram_q(ram_q3),
    .rd_valid(rd_valid3), .rd_data(rd_data3));

  // Sprite RAM stand-ins: data word is the low 12 address bits.
  always @(posedge clk) begin
    ram1_d <= ram_addr1;
    ram3_a <= ram_addr3;
    ram3_b <= ram3_a;
    ram3_c <= ram3_b;
  end
  assign ram_q1 = ram1_d[11:0];
  assign ram_q3 = ram3_c[11:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  int         m_ptr = 0, m_owner = -1, m_cnt = 0, m_last_g = -1;
  int         ncyc = 0;
  logic [3:0]  h_gnt  [HN];
  logic [15:0] h_addr [HN];
  logic        h_rst  [HN];
  int         waitc [4] = '{0, 0, 0, 0};
  logic       counting = 1'b0;
  int         cg = 0, cmg = 0, cr1 = 0, cr3 = 0;

  function automatic logic [3:0] exp_rv(input int lat, input int t);
    if (t < lat) return 4'b0;
    for (int s = t - lat; s <= t; s++) if (h_rst[s]) return 4'b0;
    return h_gnt[t - lat];
  endfunction

  always @(negedge clk) begin : cmp
    int g, cur;
    logic [3:0]  eg, er1, er3;
    logic [15:0] ea;
    g = -1;
    if (!reset) begin
      if (m_owner >= 0 && req[m_owner]) g = m_owner;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    eg = 4'b0;
    if (g >= 0) eg[g] = 1'b1;
    ea = (g >= 0) ? req_addr[g*16 +: 16] : 16'h0;
    h_gnt[ncyc]  = eg;
    h_addr[ncyc] = ea;
    h_rst[ncyc]  = reset;
    er1 = exp_rv(1, ncyc);
    er3 = exp_rv(3, ncyc);

    chk("gnt1", gnt1, eg);
    chk("gnt3", gnt3, eg);
    chk("ram_en1", ram_en1, g >= 0);
    chk("ram_en3", ram_en3, g >= 0);
    chk("ram_addr1", ram_addr1, ea);
    chk("ram_addr3", ram_addr3, ea);
    chk("rd_valid1", rd_valid1, er1);
    chk("rd_valid3", rd_valid3, er3);
    if (er1 != 4'b0) chk("rd_data1", rd_data1, h_addr[ncyc-1][11:0]);
    if (er3 != 4'b0) chk("rd_data3", rd_data3, h_addr[ncyc-3][11:0]);
    chk("gnt_onehot0", $onehot0(gnt1), 1);

    for (int b = 0; b < N; b++) begin
      if (!reset && req[b] && g != b) waitc[b]++;
      else waitc[b] = 0;
      if (req[b]) chk("starvation_bound", waitc[b] <= (N-1)*MB, 1);
    end

    if (counting) begin
      if (gnt1 != 4'b0) cg++;
      if (g >= 0) cmg++;
      if (rd_valid1 != 4'b0) cr1++;
      if (rd_valid3 != 4'b0) cr3++;
    end

    if (reset) begin
      m_ptr = 0; m_owner = -1; m_cnt = 0;
    end else if (g >= 0) begin
      cur = (g == m_owner) ? m_cnt : 0;
      if (req_lock[g] && cur < MB - 1) begin
        m_owner = g; m_cnt = cur + 1;
      end else begin
        m_owner = -1; m_cnt = 0;
      end
      m_ptr = (g + 1) % N;
    end else begin
      m_owner = -1; m_cnt = 0;
    end
    m_last_g = g;
    ncyc++;
  end

  task automatic drive(input logic rst, input logic [3:0] r, input logic [3:0] lk);
    @(posedge clk); #1;
    reset = rst; req = r; req_lock = lk;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [3:0]  eg2 [5];
    logic [15:0] ea2 [5];
    logic [3:0]  nr, nl;
    logic [63:0] na;
    eg2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ea2 = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0010};
    reset = 1'b1; req = '0; req_lock = '0;
    req_addr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};

    // Reset and idle
    drive(1'b1, 4'b0000, 4'b0000);
    drive(1'b1, 4'b1111, 4'b0000);
    chk("lit_rst_gnt", gnt1, 4'b0000);
    chk("lit_rst_en", ram_en1, 1'b0);
    chk("lit_rst_addr", ram_addr1, 16'h0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b0000, 4'b0000);
      chk("lit_idle_gnt", gnt1, 4'b0000);
      chk("lit_idle_en", ram_en1, 1'b0);
      chk("lit_idle_addr", ram_addr1, 16'h0);
      chk("lit_idle_rv", rd_valid1, 4'b0000);
    end

    // Plain round robin with return data
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b1111, 4'b0000);
      chk("lit_rr_gnt", gnt1, eg2[k]);
      chk("lit_rr_addr", ram_addr1, ea2[k]);
      if (k >= 1) begin
        chk("lit_rr_rv1", rd_valid1, eg2[k-1]);
        chk("lit_rr_rd1", rd_data1, ea2[k-1][11:0]);
      end
      if (k >= 3) chk("lit_rr_rv3", rd_valid3, eg2[k-3]);
    end

    // Burst lock: 8 grants, one to the other requester, then 8 again
    drive(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, 4'b0011, 4'b0001);
      chk("lit_burst_gnt", gnt1, (k == 8) ? 4'b0010 : 4'b0001);
    end

    // Locked owner drops request
    drive(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b0101, 4'b0001);
      chk("lit_drop_pre", gnt1, 4'b0001);
    end
    drive(1'b0, 4'b0100, 4'b0001);
    chk("lit_drop_gnt", gnt1, 4'b0100);
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, 4'b0011, 4'b0001);
      chk("lit_drop_reburst", gnt1, (k == 8) ? 4'b0010 : 4'b0001);
    end

    // Latency 3 return and reset discarding an in-flight read
    drive(1'b1, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0100, 4'b0000);
    chk("lit_lat3_gnt", gnt3, 4'b0100);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 4'b0000, 4'b0000);
      chk("lit_lat3_rv", rd_valid3, (k == 3) ? 4'b0100 : 4'b0000);
    end
    chk("lit_lat3_rd", rd_data3, 12'h030);
    drive(1'b0, 4'b0100, 4'b0000);
    chk("lit_lat3b_gnt", gnt3, 4'b0100);
    drive(1'b1, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    chk("lit_lat3b_rv2", rd_valid3, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    chk("lit_lat3b_rv3", rd_valid3, 4'b0000);
    for (int k = 0; k < 4; k++) drive(1'b0, 4'b0000, 4'b0000);

    // Random traffic with the hold-until-granted rule
    counting = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      nr = req; nl = '0; na = req_addr;
      for (int b = 0; b < N; b++) begin
        if (!(req[b] && m_last_g != b)) begin
          nr[b] = 1'($urandom_range(0, 1));
          na[b*16 +: 16] = 16'($urandom);
        end
        nl[b] = ($urandom_range(0, 3) != 0);
      end
      reset = 1'b0; req = nr; req_lock = nl; req_addr = na;
    end
    for (int k = 0; k < 5; k++) drive(1'b0, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    counting = 1'b0;
    @(negedge clk); #1;
    chk("rv1_count", cr1, cg);
    chk("rv3_count", cr3, cg);
    chk("gnt_count", cg, cmg);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_ram_arbiter.md
Name: sprite_ram_arbiter

Overview:
- Shares one synchronous-read sprite RAM between up to NUM_REQ icon/animation requesters (player icon, enemy icons, background tiles).
- Arbitration is round-robin, with optional bounded burst locking for consecutive pixel fetches.
- Read data comes back to the winning requester with a tagged valid, RAM_LATENCY cycles after its grant.
- Sits between the per-object icon blocks and the single sprite ram_block instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, sprite RAM address width.
- DATA_W, 12, pixel colour width (RGB444; 12'h000 reserved for transparent).
- RAM_LATENCY, 1, cycles from address presented to ram_q valid (1..4).
- MAX_BURST, 8, maximum consecutive grants to one locked requester (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester read request; must be held until granted.
- req_lock  in  NUM_REQ  requester asks to keep the grant on the next cycle.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot combinational grant for the current cycle.
- ram_addr  out  ADDR_W  address to sprite RAM.
- ram_en  out  1  RAM read enable, high when any grant is issued.
- ram_q  in  DATA_W  RAM read data.
- rd_valid  out  NUM_REQ  one-hot; rd_valid[i] marks rd_data as belonging to requester i.
- rd_data  out  DATA_W  read data, equal to ram_q.

Behaviour:
- Reset:
  - rr_ptr=0, lock_owner=none, burst_cnt=0.
  - Latency pipeline cleared, so rd_valid=0.
  - gnt=0, ram_en=0 and ram_addr=0 while reset is high.
- Arbitration, combinational each cycle:
  - If lock_owner=k is active and req[k]=1, grant k.
  - Otherwise grant the first asserted req scanning from rr_ptr upward, modulo NUM_REQ.
  - No req asserted: gnt=0, ram_en=0, ram_addr=0.
- ram_addr = req_addr slice of the granted requester; ram_en=|gnt.
- rr_ptr update at the clock edge, on a non-locked grant to i: rr_ptr <= (i+1) mod NUM_REQ. Unchanged when there is no grant.
- Lock:
  - On a grant to i with req_lock[i]=1 and burst_cnt < MAX_BURST-1: lock_owner <= i, burst_cnt <= burst_cnt+1.
  - Otherwise lock_owner <= none, burst_cnt <= 0, rr_ptr <= (i+1) mod NUM_REQ.
  - A locked owner dropping req releases the lock the same cycle; arbitration falls to round-robin from rr_ptr.
  - Lock is ignored while the requester is not granted.
- Starvation bound: any held req is granted within (NUM_REQ-1)*MAX_BURST+1 cycles.
- Return path:
  - The gnt vector is delayed by a RAM_LATENCY-deep shift register to form rd_valid.
  - Grant in cycle T gives rd_valid in cycle T+RAM_LATENCY, with rd_data=ram_q in that cycle.
  - Throughput is one read per cycle; back-to-back grants to different requesters give back-to-back rd_valid in the same order.
- Handshake: the requester samples gnt in cycle T and may change req_addr or drop req in T+1. Holding req after gnt issues a new read of the same or an updated address.
- Reset mid-operation: in-flight reads are discarded and no rd_valid is produced for them. Lock and pointer return to reset values.
- Simultaneous lock release and another requester's req: the new grant follows round-robin in the cycle after release.
- Address width mismatch is not checked; requesters compute addresses (frame row/col offsets) upstream.

Test Plan:
1. Reset then req=4'b0000 for 5 cycles -> gnt=0, ram_en=0, ram_addr=0, rd_valid=0 throughout.
2. req=4'b1111 held, no lock, addresses 0x0010/0x0020/0x0030/0x0040 -> gnt sequence 0001,0010,0100,1000,0001.
   - With RAM_LATENCY=1 and a RAM model returning addr[11:0], rd_valid follows one cycle later with rd_data 0x010,0x020,0x030,0x040.
3. req=4'b0011, req_lock=4'b0001, MAX_BURST=8 -> requester 0 granted 8 consecutive cycles, then requester 1 for 1 cycle, then requester 0 again for 8.
4. Locked requester 0 drops req after 3 grants while req[2]=1 -> next cycle gnt=0100, lock cleared, burst_cnt=0.
5. RAM_LATENCY=3, single grant to requester 2 at cycle 10 -> rd_valid=0100 only at cycle 13; assert reset at cycle 11 -> no rd_valid at cycle 13.
6. Random req/req_lock for 10k cycles, NUM_REQ=4, MAX_BURST=8 -> every held req granted within 25 cycles; gnt always one-hot or zero; rd_valid count equals grant count.
